whack_round_engine: RTL

Game-play engine on the far side of the game controller's start/stop handshake. It consumes the controller's startGame level and the filtered button levels (bOut1..3), lights one of three targets at a time, scores hits and penalises wrong presses. It runs the round timer and drives the stop level back into the controller's stopIn when time expires.

---
 rtl/whack_round_engine_if.sv | 24 ++
 rtl/whack_round_engine.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/whack_round_engine_if.sv
// Start/stop handshake and button/score bundle between the game controller
// (master) and the round engine (slave).
interface whack_round_engine_if;
   logic        startGame;
   logic        btn1;
   logic        btn2;
   logic        btn3;
   logic        stopOut;
   logic [2:0]  ledOut;
   logic [7:0]  score;
   logic [15:0] timeLeft;
   logic        hitPulse;
   logic        missPulse;

   modport master (
      output startGame, btn1, btn2, btn3,
      input  stopOut, ledOut, score, timeLeft, hitPulse, missPulse
   );

   modport slave (
      input  startGame, btn1, btn2, btn3,
      output stopOut, ledOut, score, timeLeft, hitPulse, missPulse
   );
endinterface

// File: rtl/whack_round_engine.sv
// Whack-a-target round engine: lights one of three targets, scores hits,
// penalises wrong presses and runs the round timer back to the controller.
module whack_round_engine #(
   parameter int unsigned CLKS_PER_TICK = 5000000,
   parameter int unsigned GAME_TICKS    = 300,
   parameter int unsigned LIT_TICKS     = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   whack_round_engine_if.slave   bus
);
   localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);
   localparam logic [7:0]    LIT_LAST  = 8'(LIT_TICKS - 1);
   localparam logic [15:0]   GAME_LEN  = 16'(GAME_TICKS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_SHOW = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          stop_q, stop_d;
   logic [2:0]    led_q, led_d;
   logic [7:0]    score_q, score_d;
   logic [15:0]   time_q, time_d;
   logic          hit_q, hit_d;
   logic          miss_q, miss_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    lit_q, lit_d;
   logic [1:0]    prev_q, prev_d;
   logic [2:0]    btn_prev_q;
   logic [3:0]    lfsr_q;

   logic [2:0] btn;
   logic [2:0] press;
   logic       tick;
   logic       wrong_press;
   logic       lit_press;
   logic [1:0] idx_raw, idx_pick;

   assign btn         = {bus.btn3, bus.btn2, bus.btn1};
   assign press       = btn & ~btn_prev_q;
   assign wrong_press = |(press & ~led_q);
   assign lit_press   = (|press) && (press == led_q);
   assign tick        = ((state_q == S_ARM) || (state_q == S_SHOW)) && (presc_q == PRESC_MAX);

   // Fold the LFSR's 4th code onto target 0, then step past the previous target.
   always_comb begin
      idx_raw  = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
      idx_pick = idx_raw;
      if (idx_raw == prev_q) begin
         idx_pick = (idx_raw == 2'd2) ? 2'd0 : idx_raw + 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      stop_d  = stop_q;
      led_d   = led_q;
      score_d = score_q;
      time_d  = time_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      presc_d = presc_q;
      lit_d   = lit_q;
      prev_d  = prev_q;
      case (state_q)
         S_IDLE: begin
            led_d  = 3'b000;
            stop_d = 1'b0;
            if (bus.startGame) begin
               state_d = S_ARM;
               score_d = 8'd0;
               time_d  = GAME_LEN;
               presc_d = '0;
            end
         end
         S_ARM, S_SHOW: begin
            if (!bus.startGame) begin
               state_d = S_IDLE;
               led_d   = 3'b000;
            end else begin
               presc_d = tick ? '0 : presc_q + PRESC_ONE;
               if (state_q == S_ARM) begin
                  led_d   = 3'b001 << idx_pick;
                  prev_d  = idx_pick;
                  lit_d   = 8'd0;
                  state_d = S_SHOW;
               end else if (wrong_press) begin
                  score_d = (score_q == 8'd0) ? 8'd0 : score_q - 8'd1;
               end else if (lit_press) begin
                  score_d = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
                  hit_d   = 1'b1;
                  led_d   = 3'b000;
                  state_d = S_ARM;
               end else if (tick) begin
                  if (lit_q == LIT_LAST) begin
                     miss_d  = 1'b1;
                     led_d   = 3'b000;
                     state_d = S_ARM;
                  end else begin
                     lit_d = lit_q + 8'd1;
                  end
               end
               // Round expiry wins over a same-cycle miss; a same-cycle hit still counts.
               if (tick) begin
                  if (time_q == 16'd1) begin
                     time_d  = 16'd0;
                     led_d   = 3'b000;
                     stop_d  = 1'b1;
                     miss_d  = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     time_d = time_q - 16'd1;
                  end
               end
            end
         end
         S_DONE: begin
            led_d  = 3'b000;
            stop_d = 1'b1;
            if (!bus.startGame) begin
               state_d = S_IDLE;
               stop_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         stop_q     <= 1'b0;
         led_q      <= 3'b000;
         score_q    <= 8'd0;
         time_q     <= 16'd0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         presc_q    <= '0;
         lit_q      <= 8'd0;
         prev_q     <= 2'd0;
         btn_prev_q <= 3'b000;
         lfsr_q     <= 4'b0001;
      end else begin
         state_q    <= state_d;
         stop_q     <= stop_d;
         led_q      <= led_d;
         score_q    <= score_d;
         time_q     <= time_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         presc_q    <= presc_d;
         lit_q      <= lit_d;
         prev_q     <= prev_d;
         btn_prev_q <= btn;
         lfsr_q     <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      end
   end

   assign bus.stopOut   = stop_q;
   assign bus.ledOut    = led_q;
   assign bus.score     = score_q;
   assign bus.timeLeft  = time_q;
   assign bus.hitPulse  = hit_q;
   assign bus.missPulse = miss_q;
endmodule
